// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit: condition encodings,
// flag bit positions and the squash FSM state type.
package bru_pkg;

  localparam logic [2:0] COND_NEVER = 3'b000;
  localparam logic [2:0] COND_Z     = 3'b001;
  localparam logic [2:0] COND_N     = 3'b010;
  localparam logic [2:0] COND_LE    = 3'b011;
  localparam logic [2:0] COND_C     = 3'b100;
  localparam logic [2:0] COND_CZ    = 3'b101;
  localparam logic [2:0] COND_V     = 3'b110;
  localparam logic [2:0] COND_ODD   = 3'b111;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    IDLE,
    SQUASH
  } state_t;

  // Index width for n entries, never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bru_cond_eval.sv
// Combinational condition evaluator: {Z,N,C,V} flags and a 3-bit selector
// produce cond_met.
module bru_cond_eval
  import bru_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [2:0] cond,
  output logic       cond_met
);

  always_comb begin
    cond_met = 1'b0;
    case (cond)
      COND_NEVER: cond_met = 1'b0;
      COND_Z:     cond_met = flags[FLAG_Z];
      COND_N:     cond_met = flags[FLAG_N];
      COND_LE:    cond_met = (flags[FLAG_N] ^ flags[FLAG_V]) | flags[FLAG_Z];
      COND_C:     cond_met = flags[FLAG_C];
      COND_CZ:    cond_met = flags[FLAG_C] | flags[FLAG_Z];
      COND_V:     cond_met = flags[FLAG_V];
      COND_ODD:   cond_met = ~flags[FLAG_Z];
      default:    cond_met = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch resolver: banked flags with write bypass, taken/nullify
// decision, redirect pulse, multi-cycle squash FSM and saturating taken counter.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter  int ADDR_W       = 32,
  parameter  int N_FLAGSETS   = 2,
  parameter  int FLUSH_CYCLES = 2,
  parameter  int CNT_W        = 16,
  localparam int FS_W         = idx_width(N_FLAGSETS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flag_we,
  input  logic [FS_W-1:0]   flag_wsel,
  input  logic [3:0]        flag_wdata,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic              br_bl,
  input  logic              br_comb,
  input  logic              br_tf,
  input  logic [2:0]        br_cond,
  input  logic [FS_W-1:0]   br_fsel,
  input  logic              br_nullify,
  input  logic              br_disp_neg,
  input  logic [ADDR_W-1:0] br_target,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              squash_o,
  output logic              nullify_o,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam int              SQ_W    = idx_width(FLUSH_CYCLES);
  localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(FLUSH_CYCLES - 1);

  logic [3:0]      flag_bank [N_FLAGSETS];
  logic [3:0]      eval_flags;
  logic            fsel_hit;
  logic            cond_met;
  logic            taken;
  logic            null_cond;
  logic            idle;
  logic            accept;
  state_t          state, state_nxt;
  logic [SQ_W-1:0] sq_cnt, sq_cnt_nxt;

  // Writes to a non-existent bank fall through the loop and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_FLAGSETS; i++) flag_bank[i] <= '0;
    end else if (flag_we) begin
      for (int i = 0; i < N_FLAGSETS; i++)
        if (int'(flag_wsel) == i) flag_bank[i] <= flag_wdata;
    end
  end

  always_comb begin
    eval_flags = '0;
    fsel_hit   = 1'b0;
    for (int i = 0; i < N_FLAGSETS; i++) begin
      if (int'(br_fsel) == i) begin
        eval_flags = flag_bank[i];
        fsel_hit   = 1'b1;
      end
    end
    if (fsel_hit && flag_we && (flag_wsel == br_fsel)) eval_flags = flag_wdata;
  end

  bru_cond_eval u_cond_eval (
    .flags    (eval_flags),
    .cond     (br_cond),
    .cond_met (cond_met)
  );

  assign taken     = br_bl | (br_comb & (cond_met ^ br_tf));
  // ,n kills the delay slot when the branch goes the "unexpected" way.
  assign null_cond = br_nullify & (br_bl | (br_comb & (taken ^ br_disp_neg)));
  assign idle      = (state == IDLE);
  assign accept    = br_valid & idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sq_cnt <= '0;
    end else begin
      state  <= state_nxt;
      sq_cnt <= sq_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sq_cnt_nxt = sq_cnt;
    br_ready   = 1'b0;
    squash_o   = 1'b0;
    case (state)
      IDLE: begin
        br_ready = 1'b1;
        if (accept && taken) begin
          state_nxt  = SQUASH;
          sq_cnt_nxt = SQ_LOAD;
        end
      end
      SQUASH: begin
        squash_o = 1'b1;
        if (sq_cnt == '0) state_nxt = IDLE;
        else              sq_cnt_nxt = sq_cnt - SQ_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      nullify_o      <= 1'b0;
      taken_cnt      <= '0;
    end else begin
      redirect_valid <= accept & taken;
      nullify_o      <= accept & null_cond;
      if (accept && taken) begin
        redirect_pc <= br_target;
        if (!(&taken_cnt)) taken_cnt <= taken_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized scoreboard bench for branch_resolve_unit: stimulus pushes predicted
// responses, a monitor pops and compares them against the DUT outputs.
module tb_branch_resolve_unit;

  localparam int ADDR_W = 32;
  localparam int NFS    = 3;
  localparam int FLUSH  = 2;
  localparam int CNT_W  = 2;
  localparam int FS_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flag_we = 1'b0;
  logic [FS_W-1:0]   flag_wsel = '0;
  logic [3:0]        flag_wdata = '0;
  logic              br_valid = 1'b0;
  logic              br_ready;
  logic              br_bl = 1'b0;
  logic              br_comb = 1'b0;
  logic              br_tf = 1'b0;
  logic [2:0]        br_cond = '0;
  logic [FS_W-1:0]   br_fsel = '0;
  logic              br_nullify = 1'b0;
  logic              br_disp_neg = 1'b0;
  logic [ADDR_W-1:0] br_target = '0;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              squash_o;
  logic              nullify_o;
  logic [CNT_W-1:0]  taken_cnt;

  branch_resolve_unit #(
    .ADDR_W(ADDR_W), .N_FLAGSETS(NFS), .FLUSH_CYCLES(FLUSH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .flag_we(flag_we), .flag_wsel(flag_wsel), .flag_wdata(flag_wdata),
    .br_valid(br_valid), .br_ready(br_ready),
    .br_bl(br_bl), .br_comb(br_comb), .br_tf(br_tf), .br_cond(br_cond),
    .br_fsel(br_fsel), .br_nullify(br_nullify), .br_disp_neg(br_disp_neg),
    .br_target(br_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .squash_o(squash_o), .nullify_o(nullify_o), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          taken;
    bit          nul;
    logic [31:0] target;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] fm [NFS];

  // monitor-side model state
  int   sq_left = 0;
  int   cnt_m = 0;
  bit   acc_prev = 1'b0;
  exp_t e_mon;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit cond_true(input logic [3:0] f, input logic [2:0] c);
    bit z, n, cy, v;
    z = f[3]; n = f[2]; cy = f[1]; v = f[0];
    case (c)
      3'd0: return 1'b0;
      3'd1: return z;
      3'd2: return n;
      3'd3: return (n != v) || z;
      3'd4: return cy;
      3'd5: return cy || z;
      3'd6: return v;
      default: return !z;
    endcase
  endfunction

  function automatic exp_t predict();
    exp_t       e;
    logic [3:0] fl;
    int         fs;
    fs = int'(br_fsel);
    fl = 4'b0000;
    if (fs < NFS) begin
      fl = fm[fs];
      if (flag_we && flag_wsel == br_fsel) fl = flag_wdata;
    end
    if (br_bl)        e.taken = 1'b1;
    else if (br_comb) e.taken = cond_true(fl, br_cond) != br_tf;
    else              e.taken = 1'b0;
    e.nul    = br_nullify && (br_bl || (br_comb && (e.taken != br_disp_neg)));
    e.target = br_target;
    return e;
  endfunction

  // One clock: decide acceptance before the edge, update the flag model at it.
  task automatic tick(output bit acc);
    int ws;
    @(negedge clk);
    acc = rst_n && br_valid && br_ready;
    if (acc) exp_q.push_back(predict());
    @(posedge clk);
    ws = int'(flag_wsel);
    if (rst_n && flag_we && ws < NFS) fm[ws] = flag_wdata;
    #1;
  endtask

  task automatic send(input bit bl, input bit comb, input bit tf, input logic [2:0] cond,
                      input logic [1:0] fsel, input bit nul, input bit neg,
                      input logic [31:0] tgt, input bit we, input logic [1:0] wsel,
                      input logic [3:0] wdata);
    bit acc;
    acc = 1'b0;
    br_valid = 1'b1; br_bl = bl; br_comb = comb; br_tf = tf; br_cond = cond;
    br_fsel = fsel; br_nullify = nul; br_disp_neg = neg; br_target = tgt;
    flag_we = we; flag_wsel = wsel; flag_wdata = wdata;
    for (int k = 0; k < 40; k++) begin
      tick(acc);
      if (acc) break;
      flag_we = 1'b0;
    end
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
    br_valid = 1'b0;
    flag_we  = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input bit rnd_flags);
    bit acc;
    for (int k = 0; k < n; k++) begin
      flag_we    = rnd_flags ? 1'($urandom) : 1'b0;
      flag_wsel  = 2'($urandom_range(0, 3));
      flag_wdata = 4'($urandom);
      tick(acc);
    end
    flag_we = 1'b0;
  endtask

  task automatic reset_pulse();
    bit acc;
    rst_n = 1'b0;
    for (int i = 0; i < NFS; i++) fm[i] = 4'b0000;
    tick(acc);
    rst_n = 1'b1;
  endtask

  task automatic send_random();
    send(($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom), 3'($urandom),
         2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom,
         1'($urandom), 2'($urandom_range(0, 3)), 4'($urandom));
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_ready", 64'(br_ready), 64'd1);
        check("rst_redirect", 64'(redirect_valid), 64'd0);
        check("rst_pc", 64'(redirect_pc), 64'd0);
        check("rst_squash", 64'(squash_o), 64'd0);
        check("rst_nullify", 64'(nullify_o), 64'd0);
        check("rst_cnt", 64'(taken_cnt), 64'd0);
        sq_left = 0;
        cnt_m = 0;
        acc_prev = 1'b0;
        exp_q.delete();
      end else begin
        if (acc_prev) begin
          if (exp_q.size() == 0) begin
            check("queue_underflow", 64'd0, 64'd1);
          end else begin
            e_mon = exp_q.pop_front();
            check("redirect_valid", 64'(redirect_valid), 64'(e_mon.taken));
            if (e_mon.taken) check("redirect_pc", 64'(redirect_pc), 64'(e_mon.target));
            check("nullify", 64'(nullify_o), 64'(e_mon.nul));
            if (e_mon.taken) begin
              sq_left = FLUSH;
              if (cnt_m < CNT_MAX) cnt_m++;
            end
          end
        end else begin
          check("idle_redirect", 64'(redirect_valid), 64'd0);
          check("idle_nullify", 64'(nullify_o), 64'd0);
        end
        check("squash", 64'(squash_o), 64'(sq_left > 0));
        check("ready", 64'(br_ready), 64'(sq_left == 0));
        check("taken_cnt", 64'(taken_cnt), 64'(cnt_m));
        if (sq_left > 0) sq_left--;
        acc_prev = br_valid && br_ready;
      end
    end
  end

  // Stimulus
  initial begin
    bit acc;
    for (int i = 0; i < NFS; i++) fm[i] = 4'b0000;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // condition sweep with bank0 = N only, both polarities
    flag_we = 1'b1; flag_wsel = 2'd0; flag_wdata = 4'b0100;
    tick(acc);
    flag_we = 1'b0;
    for (int tf = 0; tf < 2; tf++)
      for (int c = 0; c < 8; c++)
        send(1'b0, 1'b1, 1'(tf), 3'(c), 2'd0, 1'b0, 1'b0, $urandom, 1'b0, 2'd0, 4'd0);

    // BL with fixed target
    send(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 32'h0000_1040, 1'b0, 2'd0, 4'd0);

    // same-cycle bypass into bank1
    send(1'b0, 1'b1, 1'b0, 3'b001, 2'd1, 1'b0, 1'b0, 32'h0000_2000, 1'b1, 2'd1, 4'b1000);

    // nullify: backward not-taken, then forward taken
    send(1'b0, 1'b1, 1'b0, 3'b001, 2'd0, 1'b1, 1'b1, 32'h0000_3000, 1'b0, 2'd0, 4'd0);
    send(1'b0, 1'b1, 1'b0, 3'b010, 2'd0, 1'b1, 1'b0, 32'h0000_3100, 1'b0, 2'd0, 4'd0);

    // out-of-range bank: write ignored, read is 0000 (cond ~Z is taken)
    send(1'b0, 1'b1, 1'b0, 3'b111, 2'd3, 1'b0, 1'b0, 32'h0000_3200, 1'b1, 2'd3, 4'b1000);

    // reset in the middle of a squash
    send(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 32'h0000_4000, 1'b0, 2'd0, 4'd0);
    reset_pulse();

    // stall during squash and counter saturation
    for (int i = 0; i < 5; i++)
      send(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 32'h0000_5000 + 32'(i * 4),
           1'b0, 2'd0, 4'd0);
    idle_cycles(3, 1'b0);
    check("sat_cnt", 64'(taken_cnt), 64'd3);

    // randomized traffic with periodic resets
    for (int it = 0; it < 600; it++) begin
      if (it % 150 == 149) reset_pulse();
      else if ($urandom_range(0, 3) == 0) idle_cycles(1, 1'b1);
      else send_random();
    end

    idle_cycles(4, 1'b0);
    check("queue_drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
